alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be, in order: clk in 1 rising-edge clock; rst_n in 1 async active-low reset.
REQ-002 Instruction port: instr_valid in 1 instruction offered; instr in 16 {oper[15:12], rd/cond[11:8], func/immHi[7:4], rs/immLo[3:0]}; instr_ready out 1 block can accept.
REQ-003 ALU drive port: alu_dst out 16; alu_src out 16; alu_oper out 4; alu_func out 4; alu_cond out 4; alu_sign_ext_imm out 1; alu_psr out 5 {c,l,f,z,n}, current flags.
REQ-004 ALU return port: alu_result in 16; alu_flags in 5 {c,l,f,z,n}.
REQ-005 Status port: pc out 16 program counter; psr out 5 flags; done out 1 one-cycle retire pulse; illegal out 1 one-cycle pulse with done; dbg_addr in 4; dbg_data out 16 combinational register-file read.

Function
REQ-006 The block SHALL contain a 16x16 register file, a 16-bit PC and a 5-bit PSR; r0 is an ordinary writable register.
REQ-007 The FSM SHALL have states IDLE, READ, EXEC, WB; IDLE->READ on instr_valid&instr_ready; READ->EXEC; EXEC->WB; WB->IDLE, unconditionally.
REQ-008 instr_ready SHALL be 1 only in IDLE; instr is captured on the accepting edge and ignored otherwise.
REQ-009 In READ the block SHALL register the ALU operands; operands SHALL stay stable through EXEC.
REQ-010 Register forms (oper 0000, 0100, 1000): alu_func=instr[7:4], alu_dst=R[rd], alu_src=R[rs].
REQ-011 Immediate forms: alu_func=0; imm8=instr[7:0]; sign-extended (alu_sign_ext_imm=1) for oper 0101, 1001, 1010, 1011, 1100, 1110; zero-extended (alu_sign_ext_imm=0) for 0001, 0010, 0011, 0110, 0111, 1101, 1111.
REQ-012 Bcond (oper 1100): alu_cond=instr[11:8], alu_dst=pc, alu_src=sext(imm8); result is written to pc, not the register file.
REQ-013 Jcond (oper 0100, func 1100): alu_cond=instr[11:8], alu_dst=pc+1, alu_src=R[rs]; result is written to pc.
REQ-014 All other instructions: alu_cond=instr[11:8]; in EXEC the block SHALL capture alu_result and alu_flags.
REQ-015 In WB: R[rd]<=result unless the op is CMP (0000/1011), CMPI (1011), a branch, or illegal.
REQ-016 In WB, non-branch ops SHALL set pc<=pc+1 with 16-bit wrap (FFFF->0000).
REQ-017 PSR SHALL update from captured flags only for oper 0101, 0110, 0111, 1001, 1010, 1011, or oper 0000 with func 0101, 0110, 0111, 1001, 1010, 1011; otherwise it holds.
REQ-018 Illegal = oper 0000 with func 0000, 1000 or 1100; oper 0100 with func other than 1000 or 1100; oper 1000 with func not in {0000,0001,0010,0011,0100,0110}. Illegal ops SHALL do no write and no PSR update, SHALL set pc+1, and SHALL pulse done and illegal in WB.
REQ-019 done SHALL pulse in WB, exactly 3 cycles after the accepting edge; throughput is one instruction per 4 cycles.
REQ-020 When rd==rs, the operand SHALL be the pre-write value.
REQ-021 dbg_data SHALL reflect a WB write from the cycle after that write.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, pc=0, psr=0, all registers=0, done=0, illegal=0, all ALU drive outputs=0, instr_ready=1 once in IDLE.
REQ-023 Reset during READ, EXEC or WB SHALL abort the instruction with no register, PSR or pc side effect and no done pulse.

Structure
REQ-024 A shared package SHALL hold the oper/func/cond codes, the flag bit indices and the FSM state encoding.
REQ-025 The register file SHALL be a sub-module, regfile16x16, with one write port and three combinational read ports (rd, rs, dbg).
REQ-026 The ALU SHALL stay external; this block contains no arithmetic except pc+1.

Verification
REQ-027 Scenario 1: after reset, MOVI r1,0x7F (0xD17F) -> done on cycle 3; dbg r1=0x007F; pc=1; psr=0.
REQ-028 Scenario 2: r1=0x7FFF, ADD r1,r1 with the ALU model returning 0xFFFE, flags f=1, n=1 -> r1=0xFFFE; psr={c0,l0,f1,z0,n1}.
REQ-029 Scenario 3: CMPI r2,0x05 with r2=5, ALU z=1 -> r2 unchanged; psr.z=1; pc+1.
REQ-030 Scenario 4: pc=0x0010, Bcond EQ, disp 0xFE, ALU result 0x000E -> alu_src=0xFFFE; pc=0x000E; no register write.
REQ-031 Scenario 5: instr 0x0000 -> illegal and done pulse together; register file and psr unchanged; pc+1.
REQ-032 Scenario 6: assert rst_n=0 in EXEC of ADDI r3,1 -> r3=0; pc=0; no done pulse; next instr accepted from IDLE.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared codes for the ALU sequencer: opcodes, function codes, conditions,
// PSR flag positions, FSM state encoding and the small decode helpers.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_REG0  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_REG4  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_REG8  = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MULI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] FN_ADD   = 4'b0101;
    localparam logic [3:0] FN_ADDU  = 4'b0110;
    localparam logic [3:0] FN_ADDC  = 4'b0111;
    localparam logic [3:0] FN_LOAD  = 4'b1000;
    localparam logic [3:0] FN_SUB   = 4'b1001;
    localparam logic [3:0] FN_SUBC  = 4'b1010;
    localparam logic [3:0] FN_CMP   = 4'b1011;
    localparam logic [3:0] FN_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ  = 4'b0000;
    localparam logic [3:0] COND_NE  = 4'b0001;
    localparam logic [3:0] COND_UC  = 4'b1110;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    function automatic logic is_illegal(input logic [3:0] oper, input logic [3:0] func);
        logic ill;
        ill = 1'b0;
        case (oper)
            OP_REG0: ill = (func == 4'b0000) || (func == 4'b1000) || (func == 4'b1100);
            OP_REG4: ill = (func != FN_LOAD) && (func != FN_JCOND);
            OP_REG8: ill = !((func <= 4'b0100) || (func == 4'b0110));
            default: ill = 1'b0;
        endcase
        return ill;
    endfunction

    function automatic logic is_sext_op(input logic [3:0] oper);
        return (oper == OP_ADDI) || (oper == OP_SUBI) || (oper == OP_SUBCI) ||
               (oper == OP_CMPI) || (oper == OP_BCOND) || (oper == OP_MULI);
    endfunction

    function automatic logic updates_psr(input logic [3:0] oper, input logic [3:0] func);
        logic [3:0] code;
        code = (oper == OP_REG0) ? func : oper;
        return (code == 4'b0101) || (code == 4'b0110) || (code == 4'b0111) ||
               (code == 4'b1001) || (code == 4'b1010) || (code == 4'b1011);
    endfunction

endpackage

// File: rtl/regfile16x16.sv
// 16 x 16-bit register file: one write port, three combinational read ports.
module regfile16x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    input  logic [3:0]  rs_addr,
    output logic [15:0] rs_data,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    logic [15:0] mem [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data  = mem[rd_addr];
    assign rs_data  = mem[rs_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) driving an external ALU;
// owns the register file, PC and PSR.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_dst,
    output logic [15:0] alu_src,
    output logic [3:0]  alu_oper,
    output logic [3:0]  alu_func,
    output logic [3:0]  alu_cond,
    output logic        alu_sign_ext_imm,
    output logic [4:0]  alu_psr,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_flags,
    output logic [15:0] pc,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);
    import alu_sequencer_pkg::*;

    state_t      state;
    logic [15:0] instr_q;
    logic [15:0] result_q;
    logic [4:0]  flags_q;

    logic [3:0]  oper, rd, func, rs;
    logic [7:0]  imm8;
    logic [15:0] rd_data, rs_data, imm16, pc_inc;
    logic [15:0] dst_nxt, src_nxt;
    logic [3:0]  func_nxt;
    logic        sext_nxt;
    logic        reg_form, is_bcond, is_jcond, is_branch, ill, no_write, psr_upd, we;

    assign oper = instr_q[15:12];
    assign rd   = instr_q[11:8];
    assign func = instr_q[7:4];
    assign rs   = instr_q[3:0];
    assign imm8 = instr_q[7:0];

    assign pc_inc    = pc + 16'd1;
    assign reg_form  = (oper == OP_REG0) || (oper == OP_REG4) || (oper == OP_REG8);
    assign is_bcond  = (oper == OP_BCOND);
    assign is_jcond  = (oper == OP_REG4) && (func == FN_JCOND);
    assign is_branch = is_bcond || is_jcond;
    assign ill       = is_illegal(oper, func);
    assign imm16     = is_sext_op(oper) ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};

    // Compare ops only set flags; branches retarget pc instead of writing a register.
    assign no_write = is_branch || ill || (oper == OP_CMPI) ||
                      ((oper == OP_REG0) && (func == FN_CMP));
    assign psr_upd  = updates_psr(oper, func) && !ill;
    assign we       = (state == ST_WB) && !no_write;

    assign instr_ready = (state == ST_IDLE);

    always_comb begin
        dst_nxt  = rd_data;
        src_nxt  = rs_data;
        func_nxt = func;
        sext_nxt = 1'b0;
        if (!reg_form) begin
            src_nxt  = imm16;
            func_nxt = 4'd0;
            sext_nxt = is_sext_op(oper);
        end
        if (is_bcond) dst_nxt = pc;
        if (is_jcond) dst_nxt = pc_inc;
    end

    regfile16x16 u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (rd),
        .wdata    (result_q),
        .rd_addr  (rd),
        .rd_data  (rd_data),
        .rs_addr  (rs),
        .rs_data  (rs_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Instruction and ALU return are plain data holding registers; no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && instr_valid) instr_q <= instr;
        if (state == ST_EXEC) begin
            result_q <= alu_result;
            flags_q  <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pc               <= '0;
            psr              <= '0;
            done             <= 1'b0;
            illegal          <= 1'b0;
            alu_dst          <= '0;
            alu_src          <= '0;
            alu_oper         <= '0;
            alu_func         <= '0;
            alu_cond         <= '0;
            alu_sign_ext_imm <= 1'b0;
            alu_psr          <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) state <= ST_READ;
                end
                ST_READ: begin
                    alu_dst          <= dst_nxt;
                    alu_src          <= src_nxt;
                    alu_oper         <= oper;
                    alu_func         <= func_nxt;
                    alu_cond         <= rd;
                    alu_sign_ext_imm <= sext_nxt;
                    alu_psr          <= psr;
                    state            <= ST_EXEC;
                end
                ST_EXEC: begin
                    done    <= 1'b1;
                    illegal <= ill;
                    state   <= ST_WB;
                end
                ST_WB: begin
                    pc <= (is_branch && !ill) ? result_q : pc_inc;
                    if (psr_upd) psr <= flags_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table run back to back, plus
// hand-written reset and mid-instruction abort sequences.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [15:0] alu_dst, alu_src;
    logic [3:0]  alu_oper, alu_func, alu_cond;
    logic        alu_sign_ext_imm;
    logic [4:0]  alu_psr;
    logic [15:0] alu_result = '0;
    logic [4:0]  alu_flags = '0;
    logic [15:0] pc;
    logic [4:0]  psr;
    logic        done, illegal;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int failures = 0;
    logic [4:0] prev_psr;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_dst(alu_dst), .alu_src(alu_src), .alu_oper(alu_oper), .alu_func(alu_func),
        .alu_cond(alu_cond), .alu_sign_ext_imm(alu_sign_ext_imm), .alu_psr(alu_psr),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .pc(pc), .psr(psr), .done(done), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] res;
        logic [4:0]  flg;
        logic [15:0] dst;
        logic [15:0] src;
        logic [3:0]  func;
        logic        sext;
        logic        ill;
        logic [15:0] pc;
        logic [4:0]  psr;
        logic [3:0]  raddr;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int done_cyc;
        logic ill_seen;
        done_cyc = 0;
        ill_seen = 1'b0;
        check($sformatf("v%0d ready_idle", idx), {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = v.instr;
        alu_result  = v.res;
        alu_flags   = v.flg;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check($sformatf("v%0d ready_busy", idx), {31'd0, instr_ready}, 32'd0);
            if (k == 2) begin
                check($sformatf("v%0d alu_dst", idx), {16'd0, alu_dst}, {16'd0, v.dst});
                check($sformatf("v%0d alu_src", idx), {16'd0, alu_src}, {16'd0, v.src});
                check($sformatf("v%0d alu_func", idx), {28'd0, alu_func}, {28'd0, v.func});
                check($sformatf("v%0d alu_sext", idx), {31'd0, alu_sign_ext_imm}, {31'd0, v.sext});
                check($sformatf("v%0d alu_oper", idx), {28'd0, alu_oper}, {28'd0, v.instr[15:12]});
                check($sformatf("v%0d alu_cond", idx), {28'd0, alu_cond}, {28'd0, v.instr[11:8]});
                check($sformatf("v%0d alu_psr", idx), {27'd0, alu_psr}, {27'd0, prev_psr});
            end
            if (done) begin
                done_cyc = k;
                ill_seen = illegal;
                break;
            end
        end
        check($sformatf("v%0d done_cycle", idx), done_cyc, 3);
        check($sformatf("v%0d illegal", idx), {31'd0, ill_seen}, {31'd0, v.ill});
        @(negedge clk);
        dbg_addr = v.raddr;
        #1;
        check($sformatf("v%0d done_clear", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d pc", idx), {16'd0, pc}, {16'd0, v.pc});
        check($sformatf("v%0d psr", idx), {27'd0, psr}, {27'd0, v.psr});
        check($sformatf("v%0d dbg_r%0d", idx, v.raddr), {16'd0, dbg_data}, {16'd0, v.rdata});
        prev_psr = v.psr;
    endtask

    initial begin
        int pulses;
        //              instr     res       flg       dst       src       fn    sx    il    pc        psr       ra    rdata
        vecs[0]  = '{16'hD17F, 16'h007F, 5'b00000, 16'h0000, 16'h007F, 4'h0, 1'b0, 1'b0, 16'h0001, 5'b00000, 4'h1, 16'h007F};
        vecs[1]  = '{16'hD1FF, 16'h7FFF, 5'b00000, 16'h007F, 16'h00FF, 4'h0, 1'b0, 1'b0, 16'h0002, 5'b00000, 4'h1, 16'h7FFF};
        vecs[2]  = '{16'h0151, 16'hFFFE, 5'b00101, 16'h7FFF, 16'h7FFF, 4'h5, 1'b0, 1'b0, 16'h0003, 5'b00101, 4'h1, 16'hFFFE};
        vecs[3]  = '{16'hD205, 16'h0005, 5'b00000, 16'h0000, 16'h0005, 4'h0, 1'b0, 1'b0, 16'h0004, 5'b00101, 4'h2, 16'h0005};
        vecs[4]  = '{16'hB205, 16'h1234, 5'b00010, 16'h0005, 16'h0005, 4'h0, 1'b1, 1'b0, 16'h0005, 5'b00010, 4'h2, 16'h0005};
        vecs[5]  = '{16'h52FF, 16'h0004, 5'b10000, 16'h0005, 16'hFFFF, 4'h0, 1'b1, 1'b0, 16'h0006, 5'b10000, 4'h2, 16'h0004};
        vecs[6]  = '{16'h12F0, 16'h0000, 5'b00010, 16'h0004, 16'h00F0, 4'h0, 1'b0, 1'b0, 16'h0007, 5'b10000, 4'h2, 16'h0000};
        vecs[7]  = '{16'h0000, 16'hBEEF, 5'b11111, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b1, 16'h0008, 5'b10000, 4'h0, 16'h0000};
        vecs[8]  = '{16'h4310, 16'hBEEF, 5'b11111, 16'h0000, 16'h0000, 4'h1, 1'b0, 1'b1, 16'h0009, 5'b10000, 4'h3, 16'h0000};
        vecs[9]  = '{16'h8170, 16'hBEEF, 5'b11111, 16'hFFFE, 16'h0000, 4'h7, 1'b0, 1'b1, 16'h000A, 5'b10000, 4'h1, 16'hFFFE};
        vecs[10] = '{16'h8162, 16'h0042, 5'b11111, 16'hFFFE, 16'h0000, 4'h6, 1'b0, 1'b0, 16'h000B, 5'b10000, 4'h1, 16'h0042};
        vecs[11] = '{16'h01B2, 16'h9999, 5'b00001, 16'h0042, 16'h0000, 4'hB, 1'b0, 1'b0, 16'h000C, 5'b00001, 4'h1, 16'h0042};
        vecs[12] = '{16'h4EC1, 16'h0010, 5'b11111, 16'h000D, 16'h0042, 4'hC, 1'b0, 1'b0, 16'h0010, 5'b00001, 4'hE, 16'h0000};
        vecs[13] = '{16'hC0FE, 16'h000E, 5'b00000, 16'h0010, 16'hFFFE, 4'h0, 1'b1, 1'b0, 16'h000E, 5'b00001, 4'h0, 16'h0000};
        vecs[14] = '{16'h4FC0, 16'hFFFF, 5'b00000, 16'h000F, 16'h0000, 4'hC, 1'b0, 1'b0, 16'hFFFF, 5'b00001, 4'hF, 16'h0000};
        vecs[15] = '{16'hD501, 16'h0001, 5'b11111, 16'h0000, 16'h0001, 4'h0, 1'b0, 1'b0, 16'h0000, 5'b00001, 4'h5, 16'h0001};
        vecs[16] = '{16'hD322, 16'h0022, 5'b00000, 16'h0000, 16'h0022, 4'h0, 1'b0, 1'b0, 16'h0001, 5'b00001, 4'h3, 16'h0022};
        vecs[17] = '{16'hD311, 16'h0011, 5'b00000, 16'h0000, 16'h0011, 4'h0, 1'b0, 1'b0, 16'h0001, 5'b00000, 4'h3, 16'h0011};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst pc", {16'd0, pc}, 32'd0);
        check("rst psr", {27'd0, psr}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst illegal", {31'd0, illegal}, 32'd0);
        check("rst alu_dst", {16'd0, alu_dst}, 32'd0);
        check("rst alu_src", {16'd0, alu_src}, 32'd0);
        dbg_addr = 4'h7;
        #1;
        check("rst dbg_r7", {16'd0, dbg_data}, 32'd0);
        prev_psr = 5'b00000;

        for (int i = 0; i <= 16; i++) run_vec(i, vecs[i]);

        // Abort ADDI r3,1 with reset asserted during EXEC
        instr_valid = 1'b1;
        instr       = 16'h5301;
        alu_result  = 16'h0023;
        alu_flags   = 5'b11111;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort exec alu_src", {16'd0, alu_src}, 32'h0001);
        pulses = 0;
        rst_n = 1'b0;
        dbg_addr = 4'h3;
        #1;
        check("abort pc", {16'd0, pc}, 32'd0);
        check("abort psr", {27'd0, psr}, 32'd0);
        check("abort alu_src", {16'd0, alu_src}, 32'd0);
        check("abort dbg_r3", {16'd0, dbg_data}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort done_pulses", pulses, 0);
        #1;
        check("abort ready", {31'd0, instr_ready}, 32'd1);
        check("abort pc_after", {16'd0, pc}, 32'd0);
        check("abort dbg_r3_after", {16'd0, dbg_data}, 32'd0);
        prev_psr = 5'b00000;
        run_vec(17, vecs[17]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
